// File: rtl/guess_scheduler_if.sv
// Handshake and status bundle for the guess scheduler. The bench drives the
// master modport; the scheduler uses the slave modport.
interface guess_scheduler_if;
  logic        new_game;
  logic        word_load;
  logic [24:0] word_in;
  logic        guess_valid;
  logic [4:0]  guess_letter;
  logic        guess_ready;
  logic [4:0]  found_mask;
  logic [2:0]  miss_count;
  logic        result_valid;
  logic        hit;
  logic        win;
  logic        lose;
  logic [3:0]  state_o;

  modport master (
    output new_game, word_load, word_in, guess_valid, guess_letter,
    input  guess_ready, found_mask, miss_count, result_valid, hit, win, lose, state_o
  );

  modport slave (
    input  new_game, word_load, word_in, guess_valid, guess_letter,
    output guess_ready, found_mask, miss_count, result_valid, hit, win, lose, state_o
  );
endinterface

// File: rtl/guess_scheduler.sv
// Letter-guessing game sequencer: one word position compared per cycle.
// Optional REPEAT_GUESS_FILTER_EN consumes repeated letters without a compare.
module guess_scheduler #(
  parameter int unsigned MAX_MISSES = 6
) (
  input  logic              clk,
  input  logic              reset,
  guess_scheduler_if.slave  gs
);

  localparam logic [2:0] MAX_M = 3'(MAX_MISSES);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WAIT   = 4'd1,
    S_CMP0   = 4'd2,
    S_CMP1   = 4'd3,
    S_CMP2   = 4'd4,
    S_CMP3   = 4'd5,
    S_CMP4   = 4'd6,
    S_UPDATE = 4'd7,
    S_WON    = 4'd8,
    S_LOST   = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [24:0] word_q, word_d;
  logic [4:0]  letter_q, letter_d;
  logic [4:0]  mask_q, mask_d;
  logic [2:0]  miss_q, miss_d;
  logic        hitf_q, hitf_d;
  logic        rv_q, rv_d;
  logic        hit_q, hit_d;
`ifdef REPEAT_GUESS_FILTER_EN
  logic [25:0] guessed_q, guessed_d;
`endif

  // Word position under test in the current compare state.
  logic [4:0] pos_letter;
  logic [2:0] pos_idx;
  always_comb begin
    pos_letter = word_q[4:0];
    pos_idx    = 3'd4;
    case (state_q)
      S_CMP0:  begin pos_letter = word_q[24:20]; pos_idx = 3'd0; end
      S_CMP1:  begin pos_letter = word_q[19:15]; pos_idx = 3'd1; end
      S_CMP2:  begin pos_letter = word_q[14:10]; pos_idx = 3'd2; end
      S_CMP3:  begin pos_letter = word_q[9:5];   pos_idx = 3'd3; end
      default: begin pos_letter = word_q[4:0];   pos_idx = 3'd4; end
    endcase
  end

  logic       legal, take;
  logic [2:0] miss_next;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    letter_d  = letter_q;
    mask_d    = mask_q;
    miss_d    = miss_q;
    hitf_d    = hitf_q;
    rv_d      = 1'b0;
    hit_d     = 1'b0;
    miss_next = miss_q;
    legal     = (gs.guess_letter >= 5'd1) && (gs.guess_letter <= 5'd26);
    take      = gs.guess_valid && legal;
`ifdef REPEAT_GUESS_FILTER_EN
    guessed_d = guessed_q;
    take      = take && !guessed_q[gs.guess_letter - 5'd1];
`endif

    case (state_q)
      S_IDLE: begin
        if (gs.word_load) begin
          word_d  = gs.word_in;
          mask_d  = 5'd0;
          miss_d  = 3'd0;
`ifdef REPEAT_GUESS_FILTER_EN
          guessed_d = '0;
`endif
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (take) begin
          letter_d = gs.guess_letter;
          hitf_d   = 1'b0;
`ifdef REPEAT_GUESS_FILTER_EN
          guessed_d[gs.guess_letter - 5'd1] = 1'b1;
`endif
          state_d  = S_CMP0;
        end
      end
      S_CMP0, S_CMP1, S_CMP2, S_CMP3, S_CMP4: begin
        if (pos_letter == letter_q) begin
          mask_d[pos_idx] = 1'b1;
          hitf_d          = 1'b1;
        end
        state_d = (state_q == S_CMP4) ? S_UPDATE : state_t'(state_q + 4'd1);
      end
      S_UPDATE: begin
        // Result is registered so it appears together with the new counts/state.
        rv_d  = 1'b1;
        hit_d = hitf_q;
        if (!hitf_q && miss_q < MAX_M) miss_next = miss_q + 3'd1;
        miss_d = miss_next;
        if (mask_q == 5'b11111)              state_d = S_WON;
        else if (!hitf_q && miss_next == MAX_M) state_d = S_LOST;
        else                                 state_d = S_WAIT;
      end
      S_WON, S_LOST: state_d = state_q;
      default:       state_d = S_IDLE;
    endcase

    if (gs.new_game) begin
      state_d = S_IDLE;
      mask_d  = 5'd0;
      miss_d  = 3'd0;
      hitf_d  = 1'b0;
      rv_d    = 1'b0;
      hit_d   = 1'b0;
`ifdef REPEAT_GUESS_FILTER_EN
      guessed_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      letter_q <= '0;
      mask_q   <= '0;
      miss_q   <= '0;
      hitf_q   <= 1'b0;
      rv_q     <= 1'b0;
      hit_q    <= 1'b0;
`ifdef REPEAT_GUESS_FILTER_EN
      guessed_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      letter_q <= letter_d;
      mask_q   <= mask_d;
      miss_q   <= miss_d;
      hitf_q   <= hitf_d;
      rv_q     <= rv_d;
      hit_q    <= hit_d;
`ifdef REPEAT_GUESS_FILTER_EN
      guessed_q <= guessed_d;
`endif
    end
  end

  assign gs.guess_ready  = (state_q == S_WAIT);
  assign gs.found_mask   = mask_q;
  assign gs.miss_count   = miss_q;
  assign gs.result_valid = rv_q;
  assign gs.hit          = hit_q;
  assign gs.win          = (state_q == S_WON);
  assign gs.lose         = (state_q == S_LOST);
  assign gs.state_o      = state_q;

endmodule

// File: tb/tb_guess_scheduler.sv
// Bench for guess_scheduler: game-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_guess_scheduler;
  localparam int MAXM = 6;
  localparam int P_IDLE = 0, P_WAIT = 1, P_BUSY = 2, P_WON = 3, P_LOST = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  guess_scheduler_if gif();
  guess_scheduler #(.MAX_MISSES(MAXM)) dut (.clk(clk), .reset(reset), .gs(gif));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Game-level model: a guess takes six cycles, then the whole word is scored at once.
  int  m_phase = P_IDLE, m_cnt = 0, m_letter = 0, m_mask = 0, m_miss = 0;
  int  m_word[5];
  bit  m_rv = 0, m_hit = 0, m_known = 0;
  bit  m_guessed[32];

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = P_IDLE; m_mask = 0; m_miss = 0; m_rv = 0; m_hit = 0; m_known = 1;
      for (int i = 0; i < 32; i++) m_guessed[i] = 0;
    end else if (gif.new_game) begin
      m_phase = P_IDLE; m_mask = 0; m_miss = 0; m_rv = 0; m_hit = 0;
      for (int i = 0; i < 32; i++) m_guessed[i] = 0;
    end else begin
      m_rv = 0;
      case (m_phase)
        P_IDLE: if (gif.word_load) begin
          for (int p = 0; p < 5; p++) m_word[p] = int'((gif.word_in >> (20 - 5 * p)) & 25'd31);
          m_mask = 0; m_miss = 0;
          for (int i = 0; i < 32; i++) m_guessed[i] = 0;
          m_phase = P_WAIT;
        end
        P_WAIT: if (gif.guess_valid && gif.guess_letter >= 1 && gif.guess_letter <= 26) begin
          bit rep;
          rep = 0;
`ifdef REPEAT_GUESS_FILTER_EN
          rep = m_guessed[gif.guess_letter];
`endif
          m_guessed[gif.guess_letter] = 1;
          if (!rep) begin m_letter = int'(gif.guess_letter); m_cnt = 0; m_phase = P_BUSY; end
        end
        P_BUSY: if (m_cnt < 5) m_cnt++;
        else begin
          int hm;
          hm = 0;
          for (int p = 0; p < 5; p++) if (m_word[p] == m_letter) hm |= (1 << p);
          m_mask |= hm;
          m_rv = 1; m_hit = (hm != 0);
          if (!m_hit && m_miss < MAXM) m_miss++;
          if (m_mask == 31) m_phase = P_WON;
          else if (!m_hit && m_miss == MAXM) m_phase = P_LOST;
          else m_phase = P_WAIT;
        end
        default: ;
      endcase
    end
  end

  function automatic int exp_state();
    case (m_phase)
      P_IDLE:  return 0;
      P_WAIT:  return 1;
      P_BUSY:  return 2 + m_cnt;
      P_WON:   return 8;
      default: return 9;
    endcase
  endfunction

  always @(negedge clk) if (m_known) begin
    chk("state", int'(gif.state_o), exp_state());
    chk("ready", int'(gif.guess_ready), int'(m_phase == P_WAIT));
    chk("win", int'(gif.win), int'(m_phase == P_WON));
    chk("lose", int'(gif.lose), int'(m_phase == P_LOST));
    chk("result_valid", int'(gif.result_valid), int'(m_rv));
    chk("miss_count", int'(gif.miss_count), m_miss);
    if (m_rv) chk("hit", int'(gif.hit), int'(m_hit));
    if (m_phase != P_BUSY) chk("found_mask", int'(gif.found_mask), m_mask);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!gif.guess_ready && n < 50) begin step(); n++; end
    if (n >= 50) chk("ready_timeout", 0, 1);
  endtask

  task automatic load(input logic [24:0] w);
    gif.word_load = 1'b1; gif.word_in = w; step(); gif.word_load = 1'b0;
  endtask

  task automatic ng();
    gif.new_game = 1'b1; step(); gif.new_game = 1'b0;
  endtask

  task automatic guess(input int l, output int lat);
    wait_ready();
    gif.guess_valid = 1'b1; gif.guess_letter = 5'(l); step(); gif.guess_valid = 1'b0;
    lat = 0;
    while (!gif.result_valid && lat < 20) begin step(); lat++; end
    if (lat >= 20) chk("result_timeout", 0, 1);
  endtask

  // Pulse a guess and let any compare finish, without requiring a result.
  task automatic poke(input int l);
    wait_ready();
    gif.guess_valid = 1'b1; gif.guess_letter = 5'(l); step(); gif.guess_valid = 1'b0;
    repeat (10) step();
  endtask

  localparam logic [24:0] NOTRE = {5'd14, 5'd15, 5'd20, 5'd18, 5'd5};

  initial begin
    int lat;
    int miss_letters[6];
    gif.new_game = 0; gif.word_load = 0; gif.word_in = '0;
    gif.guess_valid = 0; gif.guess_letter = '0;
    reset = 1'b0;
    repeat (3) step();
    chk("rst_state", int'(gif.state_o), 0);
    chk("rst_ready", int'(gif.guess_ready), 0);
    chk("rst_rv", int'(gif.result_valid), 0);
    reset = 1'b1; step();

    // Win sequence on NOTRE.
    load(NOTRE);
    chk("load_state", int'(gif.state_o), 1);
    guess(14, lat);
    chk("latency", lat, 6);
    chk("n_hit", int'(gif.hit), 1);
    chk("n_mask", int'(gif.found_mask), 5'b00001);
    guess(15, lat); guess(20, lat); guess(18, lat); guess(5, lat);
    chk("won_mask", int'(gif.found_mask), 31);
    chk("won_state", int'(gif.state_o), 8);
    chk("won_win", int'(gif.win), 1);
    chk("won_miss", int'(gif.miss_count), 0);

    // Lose sequence: six misses.
`ifdef REPEAT_GUESS_FILTER_EN
    miss_letters = '{1, 2, 3, 4, 6, 7};
`else
    miss_letters = '{1, 1, 1, 1, 1, 1};
`endif
    ng(); load(NOTRE);
    for (int i = 0; i < 6; i++) begin
      guess(miss_letters[i], lat);
      chk("miss_hit", int'(gif.hit), 0);
      chk("miss_cnt", int'(gif.miss_count), i + 1);
    end
    chk("lost_state", int'(gif.state_o), 9);
    chk("lost_lose", int'(gif.lose), 1);
    chk("lost_ready", int'(gif.guess_ready), 0);
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd14; repeat (3) step(); gif.guess_valid = 1'b0;
    chk("lost_hold", int'(gif.state_o), 9);

    // Illegal codes are dropped.
    ng(); load(NOTRE);
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd0; step();
    gif.guess_letter = 5'd31; step(); gif.guess_valid = 1'b0;
    repeat (8) step();
    chk("drop_state", int'(gif.state_o), 1);
    chk("drop_miss", int'(gif.miss_count), 0);

    // Repeated wrong letter.
    ng(); load(NOTRE);
    poke(1);
    chk("rep1_miss", int'(gif.miss_count), 1);
    poke(1);
`ifdef REPEAT_GUESS_FILTER_EN
    chk("rep2_miss", int'(gif.miss_count), 1);
`else
    chk("rep2_miss", int'(gif.miss_count), 2);
`endif

    // new_game during CMP2 clears the partially built mask.
    ng(); load(NOTRE);
    wait_ready();
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd14; step(); gif.guess_valid = 1'b0;
    step(); step();
    chk("cmp2_state", int'(gif.state_o), 4);
    chk("cmp2_mask", int'(gif.found_mask), 1);
    ng();
    chk("ng_state", int'(gif.state_o), 0);
    chk("ng_mask", int'(gif.found_mask), 0);

    // Reset while in UPDATE suppresses the result.
    load(NOTRE);
    wait_ready();
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd14; step(); gif.guess_valid = 1'b0;
    repeat (5) step();
    chk("upd_state", int'(gif.state_o), 7);
    reset = 1'b0; step(); reset = 1'b1;
    chk("upd_rst_state", int'(gif.state_o), 0);
    chk("upd_rst_rv", int'(gif.result_valid), 0);
    repeat (3) step();

    // Randomized play against the model.
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 199) != 0);
      gif.new_game  = ($urandom_range(0, 99) == 0);
      gif.word_load = ($urandom_range(0, 5) == 0);
      gif.word_in   = {5'($urandom_range(1, 6)), 5'($urandom_range(1, 6)), 5'($urandom_range(1, 6)),
                       5'($urandom_range(1, 6)), 5'($urandom_range(1, 6))};
      gif.guess_valid  = $urandom_range(0, 1) == 1;
      gif.guess_letter = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(1, 9));
      step();
    end
    reset = 1'b1; gif.new_game = 0; gif.word_load = 0; gif.guess_valid = 0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/guess_scheduler.md
GUESS_SCHEDULER -- requirements
Module: guess_scheduler

Interface
REQ-001 SHALL have parameter MAX_MISSES, default 6, meaning misses that end the game as lost (legal 1..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port new_game  input  1  abandon the current round and return to IDLE.
REQ-005 SHALL have port word_load  input  1  latch word_in as the secret word.
REQ-006 SHALL have port word_in  input  25  five 5-bit letters; position 0 = [24:20], position 4 = [4:0].
REQ-007 SHALL have port guess_valid  input  1  guess_letter presented.
REQ-008 SHALL have port guess_letter  input  5  letter code, A=1 .. Z=26.
REQ-009 SHALL have port guess_ready  output  1  a guess is accepted this cycle if guess_valid=1.
REQ-010 SHALL have port found_mask  output  5  bit i set = position i revealed.
REQ-011 SHALL have port miss_count  output  3  wrong guesses so far.
REQ-012 SHALL have port result_valid  output  1  one-cycle pulse when a guess completes.
REQ-013 SHALL have port hit  output  1  qualified by result_valid; guess matched at least one position.
REQ-014 SHALL have port win  output  1  level, game won.
REQ-015 SHALL have port lose  output  1  level, game lost.
REQ-016 SHALL have port state_o  output  4  current FSM state encoding, for debug.

Function
REQ-017 SHALL implement states IDLE=0, WAIT=1, CMP0..CMP4=2..6, UPDATE=7, WON=8, LOST=9.
REQ-018 In IDLE, SHALL latch word_in on word_load=1, clear found_mask and miss_count, and go to WAIT.
REQ-019 SHALL drive guess_ready=1 only in WAIT.
REQ-020 In WAIT, guess_valid=1 with code 1..26 SHALL latch the letter and go to CMP0.
REQ-021 In WAIT, guess_valid=1 with code 0 or 27..31 SHALL be dropped, with no state, count or pulse change.
REQ-022 CMPi SHALL compare the latched letter with word position i, set found_mask[i] on match, OR the match into an internal hit flag, and advance to CMPi+1; CMP4 advances to UPDATE.
REQ-023 UPDATE SHALL assert result_valid=1 and hit=hit flag.
REQ-024 Latency: a guess accepted at edge N SHALL give result_valid high in the cycle after edge N+6.
REQ-025 Leaving UPDATE, a miss SHALL increment miss_count.
REQ-026 Leaving UPDATE, found_mask=5'b11111 SHALL go to WON.
REQ-027 Else leaving UPDATE, a miss with post-increment miss_count=MAX_MISSES SHALL go to LOST.
REQ-028 Else leaving UPDATE SHALL go to WAIT.
REQ-029 A guess of an already-revealed letter SHALL report hit=1 and SHALL NOT count a miss.
REQ-030 win SHALL be 1 exactly in WON and lose SHALL be 1 exactly in LOST; both states hold until new_game.
REQ-031 new_game=1 SHALL go to IDLE from any state on the next edge, overriding guess and word_load, and clear found_mask, miss_count and flags.
REQ-032 guess_valid outside WAIT, and word_load outside IDLE, SHALL be ignored.
REQ-033 miss_count SHALL never exceed MAX_MISSES and SHALL never wrap.

Reset
REQ-034 With reset=0 at an edge, SHALL enter IDLE.
REQ-035 With reset=0 at an edge, SHALL clear found_mask, miss_count, the latched word, the latched letter and the hit flag.
REQ-036 During reset, outputs SHALL be: guess_ready=0, result_valid=0, hit=0, win=0, lose=0, state_o=0.
REQ-037 reset SHALL take priority over new_game, including mid-compare.

Configuration
REQ-038 With REPEAT_GUESS_FILTER_EN defined, SHALL keep a 26-bit guessed vector, cleared on reset, new_game and word_load.
REQ-039 With REPEAT_GUESS_FILTER_EN defined, a repeat guess in WAIT SHALL be consumed with no compare, no result_valid and no miss.
REQ-040 Without REPEAT_GUESS_FILTER_EN, SHALL process every valid guess; a repeated wrong letter counts again.

Verification
REQ-041 Load word NOTRE (14,15,20,18,5); guess 14 -> result_valid 6 cycles after accept, hit=1, found_mask=00001.
REQ-042 Guess 15, 20, 18, 5 in turn -> found_mask=11111, state WON, win=1, miss_count=0.
REQ-043 Guess 1 six times, MAX_MISSES=6 -> miss_count 1..6, then LOST, lose=1, guess_ready=0.
REQ-044 Guess 0 and 31 in WAIT -> dropped, state stays WAIT, no result_valid.
REQ-045 new_game during CMP2 -> IDLE next edge, found_mask=0; reset low in UPDATE -> IDLE, no result_valid.
REQ-046 Guess 1 twice, filter defined -> miss_count=1; filter undefined -> miss_count=2.
